// File: rtl/stkctl_pkg.sv
// stkctl_pkg: shared constants for the stack controller: capacity/depth-width derivation and op decode.
package stkctl_pkg;
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;
  function automatic int dep_w(input int aw);
    return aw + 1;
  endfunction
  function automatic int cap_f(input int aw);
    return (1 << aw) + 1;
  endfunction
endpackage

// File: rtl/stkctl.sv
// stkctl: stack controller caching TOS in a register and spilling deeper entries to an external dual-port RAM.
// Optional sticky overflow/underflow error enabled by defining TRA5_STKCTL_ERR_EN.
module stkctl
  import stkctl_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] dat_i,
  input  logic          clr_i,
  output logic [DW-1:0] tos_o,
  output logic [DW-1:0] nos_o,
  output logic [AW:0]   dep_o,
  output logic          emp_o,
  output logic          ful_o,
  output logic          err_o,
  output logic [AW-1:0] radr_o,
  output logic [DW-1:0] rdat_o,
  output logic          rwre_o,
  output logic [AW-1:0] xadr_o,
  input  logic [DW-1:0] xdat_i
);
  localparam int DEPW = dep_w(AW);
  localparam logic [DEPW-1:0] CAP = DEPW'(cap_f(AW));
  logic [DEPW-1:0] r_dep;
  logic [DW-1:0]   r_tos;
  logic [AW-1:0]   w_sp;
  logic [DW-1:0]   w_nos;
  logic            w_emp;
  logic            w_ful;
  logic            w_ovf;
  logic            w_unf;
  op_e             w_op;
  always_comb begin
    w_op  = op_e'({push_i, pop_i});
    w_emp = r_dep == '0;
    w_ful = r_dep == CAP;
    w_sp  = w_emp ? '0 : AW'(r_dep - 1'b1);
    w_nos = (r_dep > DEPW'(1)) ? xdat_i : '0;
    w_ovf = (w_op == OP_PUSH) && w_ful;
    w_unf = (w_op == OP_POP) && w_emp;
  end
  assign tos_o  = r_tos;
  assign nos_o  = w_nos;
  assign dep_o  = r_dep;
  assign emp_o  = w_emp;
  assign ful_o  = w_ful;
  assign radr_o = w_sp;
  assign rdat_o = r_tos;
  assign xadr_o = w_sp - 1'b1;
  // A spill happens only on a pure push that keeps an existing TOS and has room below it.
  assign rwre_o = ena_i && (w_op == OP_PUSH) && !w_emp && !w_ful;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dep <= '0;
      r_tos <= '0;
    end else if (ena_i) begin
      case (w_op)
        OP_PUSH: if (!w_ful) begin
          r_tos <= dat_i;
          r_dep <= r_dep + 1'b1;
        end
        OP_POP: if (!w_emp) begin
          r_tos <= w_nos;
          r_dep <= r_dep - 1'b1;
        end
        OP_REPL: begin
          r_tos <= dat_i;
          if (w_emp) r_dep <= DEPW'(1);
        end
        default: ;
      endcase
    end
  end
`ifdef TRA5_STKCTL_ERR_EN
  logic r_err;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err <= 1'b0;
    else if (ena_i) r_err <= (w_ovf || w_unf) ? 1'b1 : clr_i ? 1'b0 : r_err;
  end
  assign err_o = r_err;
`else
  logic w_unused;
  assign w_unused = clr_i ^ w_ovf ^ w_unf;
  assign err_o    = 1'b0;
`endif
endmodule
